led_fade_driver: RTL and testbench

- Downstream stage of the 8-bit shifting-LED generator. Consumes the shifter's `led[7:0]` pattern and drives the physical LED pins.
- Each LED is lit at full brightness while its input bit is high.
- When the bit drops, the LED decays linearly to off through PWM dimming, giving a "comet tail" trail behind the moving light.
- Single clock domain, shared with the shifter.

---
 rtl/led_fade_driver.sv | 64 ++++++
 tb/tb_led_fade_driver.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_driver.sv
// rtl/led_fade_driver.sv - PWM comet-tail fade stage behind the shifting-LED generator
module led_fade_driver #(
    parameter int PWM_BITS = 4,
    parameter int FADE_DIV = 1024
) (
    input  logic       clki,
    input  logic       rs,
    input  logic [7:0] led_in,
    input  logic       fade_en,
    output logic [7:0] led_out,
    output logic       fading
);
    localparam int FCW = $clog2(FADE_DIV);
    localparam logic [FCW-1:0] FADE_LAST = FCW'(FADE_DIV - 1);
    localparam logic [PWM_BITS-1:0] LMAX = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0]      pwm_cnt;
    logic [FCW-1:0]           fade_cnt;
    logic                     fade_tick;
    logic [7:0][PWM_BITS-1:0] level;
    logic [7:0][PWM_BITS-1:0] level_nxt;
    logic [7:0]               drive_nxt;
    logic                     fading_nxt;

    // A driven input always wins over the tick so a re-trigger never loses a step.
    always_comb begin
        level_nxt  = level;
        drive_nxt  = '0;
        fading_nxt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (led_in[i]) begin
                level_nxt[i] = LMAX;
            end else if (!fade_en) begin
                level_nxt[i] = '0;
            end else if (fade_tick && (level[i] != '0)) begin
                level_nxt[i] = level[i] - PWM_BITS'(1);
            end
            drive_nxt[i] = (level[i] == LMAX) || (level[i] > pwm_cnt);
            fading_nxt   = fading_nxt | ((level[i] != '0) && !led_in[i]);
        end
    end

    always_ff @(posedge clki or posedge rs) begin
        if (rs) begin
            pwm_cnt   <= '0;
            fade_cnt  <= '0;
            fade_tick <= 1'b0;
            level     <= '0;
            led_out   <= '0;
            fading    <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (fade_cnt == FADE_LAST) begin
                fade_cnt <= '0;
            end else begin
                fade_cnt <= fade_cnt + FCW'(1);
            end
            fade_tick <= (fade_cnt == FADE_LAST);
            level     <= level_nxt;
            led_out   <= drive_nxt;
            fading    <= fading_nxt;
        end
    end
endmodule

// File: tb/tb_led_fade_driver.sv
// tb/tb_led_fade_driver.sv - self-checking bench for led_fade_driver against an edge-count reference model
module tb_led_fade_driver;
    localparam int FD = 4;
    localparam int LM = 15;

    logic       clki = 1'b0;
    logic       rs = 1'b1;
    logic [7:0] led_in = 8'h00;
    logic       fade_en = 1'b0;
    logic [7:0] led_out;
    logic       fading;

    int checks = 0;
    int errors = 0;

    led_fade_driver #(.PWM_BITS(4), .FADE_DIV(FD)) dut (
        .clki(clki), .rs(rs), .led_in(led_in), .fade_en(fade_en),
        .led_out(led_out), .fading(fading)
    );

    always #5 clki = ~clki;

    // Reference: tick and PWM phase derived from the number of edges since reset release.
    int         lv [8];
    int         e;
    bit         last_tick;
    bit         m_tick;
    int         m_pwm;
    logic [7:0] exp_out;
    logic       exp_fad;

    always @(posedge clki or posedge rs) begin
        if (rs) begin
            e = 0;
            last_tick = 1'b0;
            exp_out = 8'h00;
            exp_fad = 1'b0;
            for (int i = 0; i < 8; i++) lv[i] = 0;
        end else begin
            m_tick = (e > 0) && (e % FD == 0);
            m_pwm  = e % (LM + 1);
            exp_fad = 1'b0;
            for (int i = 0; i < 8; i++) begin
                exp_out[i] = (lv[i] == LM) || (lv[i] > m_pwm);
                if (lv[i] != 0 && !led_in[i]) exp_fad = 1'b1;
            end
            for (int i = 0; i < 8; i++) begin
                if (led_in[i]) lv[i] = LM;
                else if (!fade_en) lv[i] = 0;
                else if (m_tick && lv[i] > 0) lv[i] = lv[i] - 1;
            end
            last_tick = m_tick;
            e = e + 1;
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clki);
        checks++;
        if (led_out !== 8'h00 || fading !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold led_out=%h fading=%b want 00/0", led_out, fading);
        end
        rs = 1'b0;
        led_in = 8'h3C;
        fade_en = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clki);
            checks++;
            if (led_out !== exp_out || fading !== exp_fad) begin
                errors++;
                $display("FAIL reset_preop cyc %0d got %h/%b want %h/%b", c, led_out, fading, exp_out, exp_fad);
            end
        end
        checks++;
        if (led_out !== 8'h3C) begin
            errors++;
            $display("FAIL reset_preop_lit got %h want 3c", led_out);
        end
        @(posedge clki);
        #2 rs = 1'b1;
        #1;
        checks++;
        if (led_out !== 8'h00 || fading !== 1'b0) begin
            errors++;
            $display("FAIL reset_async led_out=%h fading=%b want 00/0", led_out, fading);
        end
        repeat (2) @(negedge clki);
        led_in = 8'h00;
        rs = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clki);
            checks++;
            if (led_out !== 8'h00 || fading !== 1'b0 || exp_out !== 8'h00) begin
                errors++;
                $display("FAIL reset_after cyc %0d got %h/%b want 00/0", c, led_out, fading);
            end
        end
    endtask

    task automatic test_passthrough();
        logic [7:0] pat [3];
        pat[0] = 8'h00; pat[1] = 8'h01; pat[2] = 8'h02;
        fade_en = 1'b0;
        for (int p = 0; p < 3; p++) begin
            led_in = pat[p];
            for (int c = 0; c < 20; c++) begin
                @(negedge clki);
                checks++;
                if (led_out !== exp_out || fading !== exp_fad) begin
                    errors++;
                    $display("FAIL pass_model pat %h cyc %0d got %h/%b want %h/%b", pat[p], c, led_out, fading, exp_out, exp_fad);
                end
                if (c >= 1) begin
                    checks++;
                    if (led_out !== pat[p] || fading !== 1'b0) begin
                        errors++;
                        $display("FAIL pass_follow pat %h cyc %0d got %h/%b want %h/0", pat[p], c, led_out, fading, pat[p]);
                    end
                end
            end
        end
        led_in = 8'h00;
        repeat (3) @(negedge clki);
    endtask

    task automatic test_decay();
        int lit_until_tick;
        fade_en = 1'b1;
        led_in = 8'h80;
        repeat (20) @(negedge clki);
        led_in = 8'h00;
        lit_until_tick = 1;
        for (int c = 0; c < 90; c++) begin
            @(negedge clki);
            checks++;
            if (led_out !== exp_out || fading !== exp_fad) begin
                errors++;
                $display("FAIL decay_model cyc %0d got %h/%b want %h/%b", c, led_out, fading, exp_out, exp_fad);
            end
            if (lit_until_tick != 0 && c >= 1) begin
                checks++;
                if (led_out[7] !== 1'b1) begin
                    errors++;
                    $display("FAIL decay_hold cyc %0d got %b want 1", c, led_out[7]);
                end
            end
            if (last_tick) lit_until_tick = 0;
        end
        for (int c = 0; c < 32; c++) begin
            @(negedge clki);
            checks++;
            if (led_out !== 8'h00 || fading !== 1'b0) begin
                errors++;
                $display("FAIL decay_done cyc %0d got %h/%b want 00/0", c, led_out, fading);
            end
        end
    endtask

    task automatic test_tick_rise();
        int budget;
        fade_en = 1'b1;
        led_in = 8'h01;
        repeat (4) @(negedge clki);
        led_in = 8'h00;
        budget = 0;
        while (!(lv[0] == 5 && e % FD == 0) && budget < 200) begin
            @(negedge clki);
            budget++;
        end
        checks++;
        if (budget >= 200) begin
            errors++;
            $display("FAIL tick_rise_wait timeout level %0d want 5", lv[0]);
        end
        led_in = 8'h01;
        for (int c = 0; c < 18; c++) begin
            @(negedge clki);
            checks++;
            if (led_out !== exp_out || fading !== exp_fad) begin
                errors++;
                $display("FAIL tick_rise_model cyc %0d got %h/%b want %h/%b", c, led_out, fading, exp_out, exp_fad);
            end
            if (c >= 1) begin
                checks++;
                if (led_out[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL tick_rise_steady cyc %0d got %b want 1", c, led_out[0]);
                end
            end
        end
        led_in = 8'h00;
    endtask

    task automatic test_retrigger();
        int budget;
        int ticks;
        fade_en = 1'b1;
        led_in = 8'h08;
        repeat (6) @(negedge clki);
        led_in = 8'h00;
        budget = 0;
        while (lv[3] != 7 && budget < 200) begin
            @(negedge clki);
            budget++;
        end
        checks++;
        if (budget >= 200) begin
            errors++;
            $display("FAIL retrig_wait timeout level %0d want 7", lv[3]);
        end
        led_in = 8'h08;
        for (int c = 0; c < 18; c++) begin
            @(negedge clki);
            checks++;
            if (led_out !== exp_out) begin
                errors++;
                $display("FAIL retrig_model cyc %0d got %h want %h", c, led_out, exp_out);
            end
            if (c >= 1) begin
                checks++;
                if (led_out[3] !== 1'b1) begin
                    errors++;
                    $display("FAIL retrig_steady cyc %0d got %b want 1", c, led_out[3]);
                end
            end
        end
        led_in = 8'h00;
        ticks = 0;
        budget = 0;
        while (ticks < 3 && budget < 100) begin
            @(negedge clki);
            budget++;
            if (last_tick) ticks++;
        end
        fade_en = 1'b0;
        repeat (2) @(negedge clki);
        checks++;
        if (led_out[3] !== 1'b0 || fading !== 1'b0 || budget >= 100) begin
            errors++;
            $display("FAIL retrig_drop got led3=%b fading=%b want 0/0", led_out[3], fading);
        end
        fade_en = 1'b1;
    endtask

    task automatic test_shift();
        fade_en = 1'b1;
        for (int b = 0; b < 8; b++) begin
            led_in = 8'(1 << b);
            for (int c = 0; c < 8; c++) begin
                @(negedge clki);
                checks++;
                if (led_out !== exp_out || fading !== exp_fad) begin
                    errors++;
                    $display("FAIL shift_model bit %0d cyc %0d got %h/%b want %h/%b", b, c, led_out, fading, exp_out, exp_fad);
                end
                if (c >= 1) begin
                    checks++;
                    if (led_out[b] !== 1'b1) begin
                        errors++;
                        $display("FAIL shift_head bit %0d cyc %0d got %b want 1", b, c, led_out[b]);
                    end
                end
                if (b > 0) begin
                    checks++;
                    if (fading !== 1'b1) begin
                        errors++;
                        $display("FAIL shift_fading bit %0d cyc %0d got %b want 1", b, c, fading);
                    end
                end
            end
        end
        led_in = 8'h00;
    endtask

    task automatic test_random();
        int cyc;
        int hold;
        cyc = 0;
        while (cyc < 400) begin
            led_in = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            fade_en = ($urandom_range(0, 7) != 0);
            hold = $urandom_range(1, 30);
            for (int c = 0; c < hold; c++) begin
                @(negedge clki);
                cyc++;
                checks++;
                if (led_out !== exp_out || fading !== exp_fad) begin
                    errors++;
                    $display("FAIL random cyc %0d got %h/%b want %h/%b", cyc, led_out, fading, exp_out, exp_fad);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_decay();
        test_tick_rise();
        test_retrigger();
        test_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
